ctr_monitor: RTL and testbench
==============================

CTR_MONITOR -- requirements
Module: ctr_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 8: consecutive good increments needed to assert lock; legal range 1..15.
REQ-002 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 ctr  input  3  counter value from the upstream 3-bit counter.
REQ-006 ctr_vld  input  1  ctr is sampled only on cycles where ctr_vld=1.
REQ-007 clr  input  1  synchronous clear of err, wrap_cnt and stall; does not affect state.
REQ-008 wrap_pulse  output  1  one-cycle pulse on each 7->0 transition.
REQ-009 resync_pulse  output  1  one-cycle pulse on each non-7 -> 0 transition (upstream reset).
REQ-010 err  output  1  sticky sequence error.
REQ-011 lock  output  1  high while in LOCKED.
REQ-012 wrap_cnt  output  WRAP_W  saturating count of wraps.
REQ-013 stall  output  1  sticky stall flag; present only when CTR_MON_STALL_EN is defined.

Function
REQ-014 FSM states: EMPTY (no prior sample), TRACK, LOCKED, FAULT; encoding is implementation choice.
REQ-015 Prior sample register prev[2:0] is loaded with ctr on every ctr_vld=1 cycle.
REQ-016 Good step: ctr == (prev+1) mod 8; resync step: ctr==0 and prev!=7; hold step: ctr==prev; any other value is a bad step.
REQ-017 EMPTY + ctr_vld -> TRACK, good-count=0, no pulse, no error.
REQ-018 TRACK + good step -> good-count+1; when good-count reaches LOCK_LEN -> LOCKED.
REQ-019 LOCKED + good step -> stay LOCKED.
REQ-020 TRACK/LOCKED + resync step -> TRACK, good-count=0, resync_pulse=1 next cycle, err unchanged.
REQ-021 TRACK/LOCKED + bad step -> FAULT, err set next cycle, good-count=0.
REQ-022 FAULT + good step -> TRACK, good-count=1; FAULT + any other step -> stay FAULT; err stays set.
REQ-023 Hold step: state and good-count unchanged, no flag (stall handled per REQ-031).
REQ-024 ctr_vld=0: state, prev, good-count, flags all hold; pulses deasserted.
REQ-025 All outputs registered; latency from sampled ctr to wrap_pulse/resync_pulse/err/lock change is exactly 1 cycle.
REQ-026 wrap_pulse asserts on a 7->0 good step in any state except EMPTY; wrap_cnt increments with it and saturates at 2^WRAP_W-1.
REQ-027 clr=1 and a flag-setting event in the same cycle: clr wins (flag/counter cleared, event dropped); state transition still occurs.

Reset
REQ-028 rst=0 asynchronously forces: state=EMPTY, prev=0, good-count=0, all outputs 0.
REQ-029 Reset mid-operation discards history; first sample after release is treated per REQ-017.

Configuration
REQ-030 Macro CTR_MON_STALL_EN selects stall detection.
REQ-031 Defined: 4 consecutive hold steps (5 identical valid samples) set stall next cycle, sticky until clr/reset; any non-hold step zeroes the hold counter.
REQ-032 Undefined: stall port, hold counter and related logic absent; hold steps have no effect.

Verification
REQ-033 Reset, then ctr_vld=1, ctr 0,1,2..7,0,1 continuous -> lock=1 one cycle after 8th good step, wrap_pulse once at 7->0, wrap_cnt=1, err=0.
REQ-034 Locked stream, inject ctr 3->5 -> err=1 and lock=0 next cycle; then 6,7 -> state TRACK, err remains 1 until clr pulse.
REQ-035 Locked stream at ctr=4, upstream reset drives 0 -> resync_pulse one cycle, lock=0, err=0, wrap_cnt unchanged.
REQ-036 ctr_vld toggled 1/0 every cycle over 0..7 -> identical flag results to continuous stream, no spurious pulses on vld=0 cycles.
REQ-037 WRAP_W=2, 5 wraps -> wrap_cnt saturates at 3; clr coincident with 4th wrap -> wrap_cnt=0 afterwards.
REQ-038 CTR_MON_STALL_EN defined: ctr held at 2 for 5 valid samples -> stall=1; 4 samples -> stall=0; rst=0 asserted mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/ctr_monitor.sv
// ctr_monitor: lock/wrap/resync/error monitor for an upstream 3-bit counter.
// Optional stall detection is compiled in with CTR_MON_STALL_EN.
module ctr_monitor #(
    parameter int LOCK_LEN = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ctr,
    input  logic              ctr_vld,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic              resync_pulse,
    output logic              err,
    output logic              lock,
    output logic [WRAP_W-1:0] wrap_cnt
`ifdef CTR_MON_STALL_EN
    ,
    output logic              stall
`endif
);
    typedef enum logic [1:0] {EMPTY, TRACK, LOCKED, FAULT} state_t;
    localparam logic [3:0] LL = 4'(LOCK_LEN);
    state_t state, state_nx;
    logic [2:0] prev;
    logic [3:0] gcnt, gcnt_nx;
    logic good, resync, hold, wrap, set_err, rs;
    assign good   = ctr == prev + 3'd1;
    assign resync = !good && ctr == 3'd0 && prev != 3'd7;
    assign hold   = !good && !resync && ctr == prev;
    assign wrap   = ctr_vld && state != EMPTY && good && ctr == 3'd0;
    always_comb begin
        state_nx = state;
        gcnt_nx  = gcnt;
        set_err  = 1'b0;
        rs       = 1'b0;
        if (ctr_vld) begin
            unique case (state)
                EMPTY: begin
                    state_nx = TRACK;
                    gcnt_nx  = 4'd0;
                end
                TRACK, LOCKED: begin
                    if (good) begin
                        if (state == TRACK) begin
                            gcnt_nx  = gcnt + 4'd1;
                            state_nx = (gcnt + 4'd1 >= LL) ? LOCKED : TRACK;
                        end
                    end else if (resync) begin
                        state_nx = TRACK;
                        gcnt_nx  = 4'd0;
                        rs       = 1'b1;
                    end else if (!hold) begin
                        state_nx = FAULT;
                        gcnt_nx  = 4'd0;
                        set_err  = 1'b1;
                    end
                end
                FAULT: begin
                    if (good) begin
                        state_nx = (LL <= 4'd1) ? LOCKED : TRACK;
                        gcnt_nx  = 4'd1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EMPTY;
            prev         <= 3'd0;
            gcnt         <= 4'd0;
            wrap_pulse   <= 1'b0;
            resync_pulse <= 1'b0;
            err          <= 1'b0;
            lock         <= 1'b0;
            wrap_cnt     <= '0;
        end else begin
            state        <= state_nx;
            gcnt         <= gcnt_nx;
            prev         <= ctr_vld ? ctr : prev;
            wrap_pulse   <= wrap;
            resync_pulse <= rs;
            lock         <= state_nx == LOCKED;
            err          <= clr ? 1'b0 : (err | set_err);
            wrap_cnt     <= clr ? '0 : (wrap && wrap_cnt != '1) ? wrap_cnt + WRAP_W'(1) : wrap_cnt;
        end
    end
`ifdef CTR_MON_STALL_EN
    // hcnt counts consecutive hold steps, saturating at 4
    logic [2:0] hcnt;
    logic       step;
    assign step = ctr_vld && state != EMPTY;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt  <= 3'd0;
            stall <= 1'b0;
        end else begin
            hcnt  <= !step ? hcnt : !hold ? 3'd0 : (hcnt == 3'd4) ? hcnt : hcnt + 3'd1;
            stall <= clr ? 1'b0 : (stall | (step && hold && hcnt >= 3'd3));
        end
    end
`endif
endmodule

// File: tb/tb_ctr_monitor.sv
// tb_ctr_monitor: randomized and directed checks of two ctr_monitor instances
// (default widths, and WRAP_W=2 / LOCK_LEN=3) against a sequence-level model.
module tb_ctr_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] ctr = 3'd0;
    logic       ctr_vld = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] wp, rp, er, lk;
    logic [7:0] wc0;
    logic [1:0] wc1;
`ifdef CTR_MON_STALL_EN
    logic [1:0] st;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int lock_len[2] = '{8, 3};
    int wmax[2] = '{255, 3};
    bit has_prev[2], flt[2], e_wp[2], e_rp[2], e_err[2], e_lock[2], e_st[2];
    int run[2], pv[2], e_wc[2], hc[2];
    int lastc = 0;

    always #5 clk = ~clk;

    ctr_monitor u0 (
        .clk(clk), .rst(rst), .ctr(ctr), .ctr_vld(ctr_vld), .clr(clr),
        .wrap_pulse(wp[0]), .resync_pulse(rp[0]), .err(er[0]), .lock(lk[0]), .wrap_cnt(wc0)
`ifdef CTR_MON_STALL_EN
        , .stall(st[0])
`endif
    );
    ctr_monitor #(.LOCK_LEN(3), .WRAP_W(2)) u1 (
        .clk(clk), .rst(rst), .ctr(ctr), .ctr_vld(ctr_vld), .clr(clr),
        .wrap_pulse(wp[1]), .resync_pulse(rp[1]), .err(er[1]), .lock(lk[1]), .wrap_cnt(wc1)
`ifdef CTR_MON_STALL_EN
        , .stall(st[1])
`endif
    );

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            has_prev[k] = 0; flt[k] = 0; run[k] = 0; pv[k] = 0; hc[k] = 0;
            e_wp[k] = 0; e_rp[k] = 0; e_err[k] = 0; e_lock[k] = 0; e_wc[k] = 0; e_st[k] = 0;
        end
    endtask

    task automatic model(int k, bit v, int c, bit cl);
        bit g, r, h, w;
        e_wp[k] = 0;
        e_rp[k] = 0;
        if (v) begin
            if (has_prev[k]) begin
                g = c == (pv[k] + 1) % 8;
                r = !g && c == 0 && pv[k] != 7;
                h = !g && !r && c == pv[k];
                w = g && c == 0;
                if (flt[k]) begin
                    if (g) begin flt[k] = 0; run[k] = 1; end
                end else if (g) run[k]++;
                else if (r) begin run[k] = 0; e_rp[k] = 1; end
                else if (!h) begin flt[k] = 1; run[k] = 0; e_err[k] = 1; end
                e_wp[k] = w;
                if (w && e_wc[k] < wmax[k]) e_wc[k]++;
                hc[k] = h ? hc[k] + 1 : 0;
                if (hc[k] >= 4) e_st[k] = 1;
            end else begin
                run[k] = 0;
                flt[k] = 0;
            end
            has_prev[k] = 1;
            pv[k] = c;
        end
        if (cl) begin e_err[k] = 0; e_wc[k] = 0; e_st[k] = 0; end
        e_lock[k] = has_prev[k] && !flt[k] && run[k] >= lock_len[k];
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wrap_pulse%0d", k), int'(wp[k]), int'(e_wp[k]));
            chk($sformatf("resync_pulse%0d", k), int'(rp[k]), int'(e_rp[k]));
            chk($sformatf("err%0d", k), int'(er[k]), int'(e_err[k]));
            chk($sformatf("lock%0d", k), int'(lk[k]), int'(e_lock[k]));
            chk($sformatf("wrap_cnt%0d", k), k == 0 ? int'(wc0) : int'(wc1), e_wc[k]);
`ifdef CTR_MON_STALL_EN
            chk($sformatf("stall%0d", k), int'(st[k]), int'(e_st[k]));
`endif
        end
    endtask

    task automatic step(bit v, int c, bit cl);
        ctr_vld = v;
        ctr = 3'(c);
        clr = cl;
        if (v) lastc = c;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model(k, v, c, cl);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ctr_vld = 1'b0;
        clr = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int r, c;
        do_reset();
        // continuous stream to lock and first wrap
        for (int i = 0; i < 10; i++) begin
            step(1, i % 8, 0);
            if (i == 8) begin
                chk("lock_after_8_good", int'(lk[0]), 1);
                chk("wrap_once", int'(wp[0]), 1);
            end
        end
        chk("wrap_cnt_one", int'(wc0), 1);
        chk("no_err", int'(er[0]), 0);
        // sequence error while locked, then recovery to TRACK
        step(1, 2, 0); step(1, 3, 0); step(1, 5, 0);
        chk("err_on_skip", int'(er[0]), 1);
        chk("unlock_on_skip", int'(lk[0]), 0);
        step(1, 6, 0); step(1, 7, 0);
        chk("err_sticky", int'(er[0]), 1);
        step(0, 0, 1);
        chk("err_cleared", int'(er[0]), 0);
        // upstream reset while locked at 4
        do_reset();
        for (int i = 0; i < 13; i++) step(1, i % 8, 0);
        chk("locked_at_4", int'(lk[0]), 1);
        step(1, 0, 0);
        chk("resync_pulse", int'(rp[0]), 1);
        chk("resync_unlock", int'(lk[0]), 0);
        chk("resync_no_err", int'(er[0]), 0);
        chk("resync_wrap_cnt", int'(wc0), 1);
        step(1, 1, 0);
        chk("resync_one_cycle", int'(rp[0]), 0);
        // toggled valid
        do_reset();
        for (int i = 0; i < 20; i++) step(i % 2 == 0, (i / 2) % 8, 0);
        step(0, 3, 0);
        chk("toggle_lock", int'(lk[0]), 1);
        // narrow wrap counter saturation
        do_reset();
        for (int i = 0; i <= 40; i++) step(1, i % 8, 0);
        chk("wrap_sat", int'(wc1), 3);
        do_reset();
        for (int i = 0; i <= 32; i++) step(1, i % 8, i == 32);
        chk("wrap_clr_wins", int'(wc1), 0);
`ifdef CTR_MON_STALL_EN
        do_reset();
        step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 2, 0);
        chk("stall_4_samples", int'(st[0]), 0);
        step(1, 2, 0);
        chk("stall_5_samples", int'(st[0]), 1);
        step(1, 3, 0);
        chk("stall_sticky", int'(st[0]), 1);
`endif
        // asynchronous reset mid-stream
        step(1, 4, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_lock", int'(lk[0]), 0);
        chk("async_rst_wrap_cnt", int'(wc0), 0);
        do_reset();
        // randomized stream biased toward plausible counter behaviour
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            c = r < 6 ? (lastc + 1) % 8 : r < 8 ? lastc : r < 9 ? 0 : int'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 4) != 0, c, $urandom_range(0, 39) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
